// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- bundle of hazard inputs and pipeline-control outputs
// shared between the decode/EX stages and hazard_ctrl.
//   master : the pipeline side; drives hazard inputs, reads controls
//   slave  : hazard_ctrl; reads hazard inputs, drives controls
// Inputs : id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_valid,
//          ex_rd, ex_load, br_taken, mem_busy
// Outputs: pc_en, ifid_en, pipe_en, hazflush (active-low bubble), flush,
//          stall_cnt, flush_cnt, state
interface hazard_ctrl_if #(
  parameter int CNTW = 16
);
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic            ex_load;
  logic            br_taken;
  logic            mem_busy;
  logic            pc_en;
  logic            ifid_en;
  logic            pipe_en;
  logic            hazflush;
  logic            flush;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;
  logic [1:0]      state;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_valid, ex_rd, ex_load, br_taken, mem_busy,
    input  pc_en, ifid_en, pipe_en, hazflush, flush,
           stall_cnt, flush_cnt, state
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           ex_valid, ex_rd, ex_load, br_taken, mem_busy,
    output pc_en, ifid_en, pipe_en, hazflush, flush,
           stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline sequencing controller for the five-stage RV32 core.
// Detects load-use hazards against EX, inserts bubbles, flushes wrong-path
// instructions on taken branches, freezes the pipe while data memory is busy
// and keeps saturating stall/flush event counters.
// Ports:
//   clk : core clock, rising edge
//   rst : synchronous active-low reset
//   hz  : hazard_ctrl_if.slave (hazard inputs in, pipeline controls out)
// Control outputs are Mealy: they react to the inputs in the same cycle.
module hazard_ctrl #(
  parameter int CNTW      = 16,
  parameter int LU_CYC    = 1,
  parameter int FLUSH_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [2:0] LU_LOAD  = 3'(LU_CYC - 1);
  localparam logic [2:0] FL_LOAD  = 3'(FLUSH_CYC - 1);
  localparam bit         LU_MULTI = (LU_CYC > 1);
  localparam bit         FL_MULTI = (FLUSH_CYC > 1);

  typedef enum logic [2:0] {
    M_NORMAL   = 3'd0,
    M_BUBBLE   = 3'd1,
    M_FLUSHING = 3'd2,
    M_FREEZE   = 3'd3,
    M_RESET    = 3'd4
  } mode_t;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [2:0]      cnt;
  logic [2:0]      cnt_nxt;
  logic            pend_flush;
  logic            pend_nxt;
  logic            flush_inc;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;
  logic            luh;
  logic            flush_req;
  mode_t           mode;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    luh = hz.id_valid & hz.ex_valid & hz.ex_load & (hz.ex_rd != 5'd0) &
          ((hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd)) |
           (hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd)));
    flush_req = hz.br_taken | pend_flush;
  end

  // Cycle mode selection: reset > mem_busy > flush request > load-use.
  always_comb begin
    mode = M_NORMAL;
    if (!rst) begin
      mode = M_RESET;
    end else if (hz.mem_busy) begin
      mode = M_FREEZE;
    end else begin
      case (state)
        RUN: begin
          if (flush_req) begin
            mode = M_FLUSHING;
          end else if (luh) begin
            mode = M_BUBBLE;
          end else begin
            mode = M_NORMAL;
          end
        end
        STALL: begin
          if (flush_req) begin
            mode = M_FLUSHING;
          end else begin
            mode = M_BUBBLE;
          end
        end
        // A new br_taken here targets an instruction already being killed.
        FLUSH:   mode = M_FLUSHING;
        default: mode = M_NORMAL;
      endcase
    end
  end

  // Next-state, sequence counter and pending-flush logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend_flush;
    flush_inc = 1'b0;
    case (mode)
      M_RESET: begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
        pend_nxt  = 1'b0;
      end
      M_FREEZE: begin
        // State and cnt hold; remember a branch resolved while frozen.
        if (hz.br_taken) begin
          pend_nxt = 1'b1;
        end else begin
          pend_nxt = pend_flush;
        end
      end
      M_FLUSHING: begin
        if (state == FLUSH) begin
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) begin
            state_nxt = RUN;
          end else begin
            state_nxt = FLUSH;
          end
        end else begin
          pend_nxt  = 1'b0;
          flush_inc = 1'b1;
          if (FL_MULTI) begin
            state_nxt = FLUSH;
            cnt_nxt   = FL_LOAD;
          end else begin
            state_nxt = RUN;
            cnt_nxt   = 3'd0;
          end
        end
      end
      M_BUBBLE: begin
        if (state == STALL) begin
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) begin
            state_nxt = RUN;
          end else begin
            state_nxt = STALL;
          end
        end else if (LU_MULTI) begin
          state_nxt = STALL;
          cnt_nxt   = LU_LOAD;
        end else begin
          state_nxt = RUN;
          cnt_nxt   = 3'd0;
        end
      end
      M_NORMAL: begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // State register, sequence counter and event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      cnt        <= 3'd0;
      pend_flush <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pend_flush <= pend_nxt;
      if (((mode == M_BUBBLE) || (mode == M_FREEZE)) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush_inc && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

  // Pipeline control decode from the current cycle mode.
  always_comb begin
    hz.pc_en    = 1'b0;
    hz.ifid_en  = 1'b0;
    hz.pipe_en  = 1'b0;
    hz.hazflush = 1'b1;
    hz.flush    = 1'b0;
    case (mode)
      M_NORMAL: begin
        hz.pc_en   = 1'b1;
        hz.ifid_en = 1'b1;
        hz.pipe_en = 1'b1;
      end
      M_BUBBLE: begin
        hz.pipe_en  = 1'b1;
        hz.hazflush = 1'b0;
      end
      M_FLUSHING: begin
        hz.pc_en   = 1'b1;
        hz.ifid_en = 1'b1;
        hz.pipe_en = 1'b1;
        hz.flush   = 1'b1;
      end
      M_FREEZE: hz.pc_en = 1'b0;
      M_RESET:  hz.pc_en = 1'b0;
      default:  hz.pc_en = 1'b0;
    endcase
  end

  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;
  assign hz.state     = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- scoreboard bench for hazard_ctrl.
// dut_a: CNTW=16, LU_CYC=1, FLUSH_CYC=2.  dut_b: CNTW=4, LU_CYC=3, FLUSH_CYC=1.
// Each step drives one DUT (the other is held in reset), pushes the expected
// outputs for that cycle, and a negedge checker pops and compares them.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_load;
    logic       br_taken;
    logic       mem_busy;
  } in_t;

  typedef struct packed {
    logic        pc_en;
    logic        ifid_en;
    logic        pipe_en;
    logic        hazflush;
    logic        flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } out_t;

  typedef struct {
    int   which;
    int   id;
    out_t exp;
  } ent_t;

  localparam int NRM = 0;
  localparam int BUB = 1;
  localparam int FLS = 2;
  localparam int FRZ = 3;
  localparam int RST = 4;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  in_t  in_a;
  in_t  in_b;
  out_t obs_a;
  out_t obs_b;
  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNTW(16)) ifa ();
  hazard_ctrl_if #(.CNTW(4))  ifb ();

  hazard_ctrl #(.CNTW(16), .LU_CYC(1), .FLUSH_CYC(2)) dut_a (
    .clk (clk), .rst (rst_a), .hz (ifa.slave)
  );
  hazard_ctrl #(.CNTW(4), .LU_CYC(3), .FLUSH_CYC(1)) dut_b (
    .clk (clk), .rst (rst_b), .hz (ifb.slave)
  );

  assign rst_a           = in_a.rst;
  assign ifa.id_valid    = in_a.id_valid;
  assign ifa.id_rs1      = in_a.id_rs1;
  assign ifa.id_rs2      = in_a.id_rs2;
  assign ifa.id_rs1_used = in_a.id_rs1_used;
  assign ifa.id_rs2_used = in_a.id_rs2_used;
  assign ifa.ex_valid    = in_a.ex_valid;
  assign ifa.ex_rd       = in_a.ex_rd;
  assign ifa.ex_load     = in_a.ex_load;
  assign ifa.br_taken    = in_a.br_taken;
  assign ifa.mem_busy    = in_a.mem_busy;

  assign rst_b           = in_b.rst;
  assign ifb.id_valid    = in_b.id_valid;
  assign ifb.id_rs1      = in_b.id_rs1;
  assign ifb.id_rs2      = in_b.id_rs2;
  assign ifb.id_rs1_used = in_b.id_rs1_used;
  assign ifb.id_rs2_used = in_b.id_rs2_used;
  assign ifb.ex_valid    = in_b.ex_valid;
  assign ifb.ex_rd       = in_b.ex_rd;
  assign ifb.ex_load     = in_b.ex_load;
  assign ifb.br_taken    = in_b.br_taken;
  assign ifb.mem_busy    = in_b.mem_busy;

  assign obs_a = {ifa.pc_en, ifa.ifid_en, ifa.pipe_en, ifa.hazflush, ifa.flush,
                  ifa.state, ifa.stall_cnt, ifa.flush_cnt};
  assign obs_b = {ifb.pc_en, ifb.ifid_en, ifb.pipe_en, ifb.hazflush, ifb.flush,
                  ifb.state, 12'd0, ifb.stall_cnt, 12'd0, ifb.flush_cnt};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic in_t s_idle();
    in_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic in_t s_luh(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd);
    in_t s;
    s = s_idle();
    s.id_valid    = 1'b1;
    s.id_rs1      = rs1;
    s.id_rs2      = rs2;
    s.id_rs1_used = u1;
    s.id_rs2_used = u2;
    s.ex_valid    = 1'b1;
    s.ex_rd       = rd;
    s.ex_load     = 1'b1;
    return s;
  endfunction

  function automatic out_t mk(input int m, input logic [1:0] st, input int sc, input int fc);
    out_t o;
    case (m)
      NRM:     {o.pc_en, o.ifid_en, o.pipe_en, o.hazflush, o.flush} = 5'b11110;
      BUB:     {o.pc_en, o.ifid_en, o.pipe_en, o.hazflush, o.flush} = 5'b00100;
      FLS:     {o.pc_en, o.ifid_en, o.pipe_en, o.hazflush, o.flush} = 5'b11111;
      default: {o.pc_en, o.ifid_en, o.pipe_en, o.hazflush, o.flush} = 5'b00010;
    endcase
    o.state     = st;
    o.stall_cnt = 16'(sc);
    o.flush_cnt = 16'(fc);
    return o;
  endfunction

  // Drive one cycle on the selected DUT and queue the outputs expected in it.
  task automatic step(input int which, input in_t stim, input int m,
                      input logic [1:0] st, input int sc, input int fc);
    ent_t e;
    in_t  hold;
    hold = '0;
    if (which == 0) begin
      in_a = stim;
      in_b = hold;
    end else begin
      in_a = hold;
      in_b = stim;
    end
    e.which = which;
    e.id    = step_id;
    e.exp   = mk(m, st, sc, fc);
    q.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  // Compare DUT outputs mid-cycle against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      ent_t e;
      e = q.pop_front();
      if (e.which == 0) begin
        check_eq($sformatf("A_step%0d", e.id), 64'(obs_a), 64'(e.exp));
      end else begin
        check_eq($sformatf("B_step%0d", e.id), 64'(obs_b), 64'(e.exp));
      end
    end
  end

  initial begin
    in_t s;
    int  sc;
    in_t hold;
    hold = '0;
    in_a = hold;
    in_b = hold;
    repeat (3) @(posedge clk);
    #1;

    // ---------------- dut_a: LU_CYC=1, FLUSH_CYC=2 ----------------
    step(0, hold, RST, 2'd0, 0, 0);
    step(0, s_idle(), NRM, 2'd0, 0, 0);
    // load x5 in EX, add reading x5 in ID: one bubble cycle
    step(0, s_luh(5'd5, 5'd0, 1'b1, 1'b0, 5'd5), BUB, 2'd0, 0, 0);
    step(0, s_idle(), NRM, 2'd0, 1, 0);
    // non-hazards
    step(0, s_luh(5'd0, 5'd0, 1'b1, 1'b1, 5'd0), NRM, 2'd0, 1, 0);
    step(0, s_luh(5'd3, 5'd5, 1'b1, 1'b0, 5'd5), NRM, 2'd0, 1, 0);
    s = s_luh(5'd5, 5'd0, 1'b1, 1'b0, 5'd5); s.ex_load = 1'b0;
    step(0, s, NRM, 2'd0, 1, 0);
    s = s_luh(5'd5, 5'd0, 1'b1, 1'b0, 5'd5); s.id_valid = 1'b0;
    step(0, s, NRM, 2'd0, 1, 0);
    // rs2 match with rs2 used
    step(0, s_luh(5'd3, 5'd5, 1'b1, 1'b1, 5'd5), BUB, 2'd0, 1, 0);
    step(0, s_idle(), NRM, 2'd0, 2, 0);
    // taken branch: two flush cycles RUN->FLUSH->RUN
    s = s_idle(); s.br_taken = 1'b1;
    step(0, s, FLS, 2'd0, 2, 0);
    step(0, s_idle(), FLS, 2'd2, 2, 1);
    step(0, s_idle(), NRM, 2'd0, 2, 1);
    // branch during mem_busy: three freeze cycles then the pending flush
    s = s_idle(); s.br_taken = 1'b1; s.mem_busy = 1'b1;
    step(0, s, FRZ, 2'd0, 2, 1);
    step(0, s, FRZ, 2'd0, 3, 1);
    step(0, s, FRZ, 2'd0, 4, 1);
    step(0, s_idle(), FLS, 2'd0, 5, 1);
    step(0, s_idle(), FLS, 2'd2, 5, 2);
    step(0, s_idle(), NRM, 2'd0, 5, 2);
    // branch with load-use in RUN: flush wins, no bubble
    s = s_luh(5'd5, 5'd0, 1'b1, 1'b0, 5'd5); s.br_taken = 1'b1;
    step(0, s, FLS, 2'd0, 5, 2);
    step(0, s_idle(), FLS, 2'd2, 5, 3);
    step(0, s_idle(), NRM, 2'd0, 5, 3);
    // new branch during FLUSH ignored
    s = s_idle(); s.br_taken = 1'b1;
    step(0, s, FLS, 2'd0, 5, 3);
    step(0, s, FLS, 2'd2, 5, 4);
    step(0, s_idle(), NRM, 2'd0, 5, 4);
    // mem_busy inside FLUSH extends the flush sequence
    s = s_idle(); s.br_taken = 1'b1;
    step(0, s, FLS, 2'd0, 5, 4);
    s = s_idle(); s.mem_busy = 1'b1;
    step(0, s, FRZ, 2'd2, 5, 5);
    step(0, s_idle(), FLS, 2'd2, 6, 5);
    step(0, s_idle(), NRM, 2'd0, 6, 5);

    // ---------------- dut_b: CNTW=4, LU_CYC=3, FLUSH_CYC=1 ----------------
    step(1, hold, RST, 2'd0, 0, 0);
    step(1, s_idle(), NRM, 2'd0, 0, 0);
    // three-cycle load-use stall
    step(1, s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7), BUB, 2'd0, 0, 0);
    step(1, s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7), BUB, 2'd1, 1, 0);
    step(1, s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7), BUB, 2'd1, 2, 0);
    step(1, s_idle(), NRM, 2'd0, 3, 0);
    // mem_busy inside STALL extends the stall
    step(1, s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7), BUB, 2'd0, 3, 0);
    s = s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7); s.mem_busy = 1'b1;
    step(1, s, FRZ, 2'd1, 4, 0);
    step(1, s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7), BUB, 2'd1, 5, 0);
    step(1, s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7), BUB, 2'd1, 6, 0);
    step(1, s_idle(), NRM, 2'd0, 7, 0);
    // flush request preempts STALL
    step(1, s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7), BUB, 2'd0, 7, 0);
    s = s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7); s.br_taken = 1'b1;
    step(1, s, FLS, 2'd1, 8, 0);
    step(1, s_idle(), NRM, 2'd0, 8, 1);
    // reset on the second STALL cycle abandons the stall
    step(1, s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7), BUB, 2'd0, 8, 1);
    s = s_luh(5'd7, 5'd0, 1'b1, 1'b0, 5'd7); s.rst = 1'b0;
    step(1, s, RST, 2'd1, 9, 1);
    step(1, s_idle(), NRM, 2'd0, 0, 0);
    // 20 load-use stalls: 60 stall cycles, counter saturates at 15
    sc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, s_luh(5'd9, 5'd9, 1'b0, 1'b1, 5'd9), BUB, 2'd0, sc, 0);
      sc = (sc >= 15) ? 15 : sc + 1;
      step(1, s_luh(5'd9, 5'd9, 1'b0, 1'b1, 5'd9), BUB, 2'd1, sc, 0);
      sc = (sc >= 15) ? 15 : sc + 1;
      step(1, s_luh(5'd9, 5'd9, 1'b0, 1'b1, 5'd9), BUB, 2'd1, sc, 0);
      sc = (sc >= 15) ? 15 : sc + 1;
    end
    step(1, s_idle(), NRM, 2'd0, 15, 0);
    // single-cycle flush
    s = s_idle(); s.br_taken = 1'b1;
    step(1, s, FLS, 2'd0, 15, 0);
    step(1, s_idle(), NRM, 2'd0, 15, 1);

    @(negedge clk);
    #1;
    check_eq("queue_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32 core. It sits beside the decode stage and drives the IF/ID and ID/EX pipeline-register enables, the ID/EX bubble input (`hazflush`) and the branch `flush` line. It detects load-use hazards against the instruction in EX, inserts bubbles, flushes wrong-path instructions on a taken branch, freezes the pipe while data memory is busy, and keeps stall and flush event counters.

## Interface
- `CNTW`, 16, width of the saturating stall and flush counters.
- `LU_CYC`, 1, number of bubble cycles per load-use hazard (legal range 1..7).
- `FLUSH_CYC`, 1, number of cycles `flush` stays asserted per taken branch (legal range 1..7).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-low reset.
- `id_valid`  in  1  decode stage holds a real instruction.
- `id_rs1`, `id_rs2`  in  5 each  source register addresses of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  source actually read (cw[14], cw[13]).
- `ex_valid`  in  1  EX holds a real instruction.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_load`  in  1  instruction in EX is a load.
- `br_taken`  in  1  branch/jump resolved taken in EX this cycle.
- `mem_busy`  in  1  data memory not ready; the whole pipe must hold.
- `pc_en`  out  1  PC register enable.
- `ifid_en`  out  1  IF/ID enable.
- `pipe_en`  out  1  ID/EX enable.
- `hazflush`  out  1  active-low; 0 clears the ID/EX data registers (bubble).
- `flush`  out  1  clears IF/ID and the ID/EX control word.
- `stall_cnt`  out  CNTW  cycles with `pc_en`=0 since reset, excluding reset cycles.
- `flush_cnt`  out  CNTW  taken-branch flush events since reset.
- `state`  out  2  FSM state, for debug.

## Operation

Load-use hazard `luh` = `id_valid` & `ex_valid` & `ex_load` & `ex_rd`≠0 & ((`id_rs1_used` & `id_rs1`==`ex_rd`) | (`id_rs2_used` & `id_rs2`==`ex_rd`)).

FSM states: RUN=0, STALL=1, FLUSH=2. There is also a 3-bit down-counter `cnt` and a 1-bit `pend_flush` flag.

Output modes. Outputs are Mealy and apply in the same cycle:
- NORMAL: `pc_en`, `ifid_en`, `pipe_en` = 1; `hazflush`=1; `flush`=0.
- BUBBLE: `pc_en`=`ifid_en`=0; `pipe_en`=1; `hazflush`=0; `flush`=0.
- FLUSHING: all enables 1; `hazflush`=1; `flush`=1.
- FREEZE: all enables 0; `hazflush`=1; `flush`=0.

Priority in each cycle is: reset, then `mem_busy`, then flush request, then `luh`. The flush request is `br_taken` | `pend_flush`.
- `mem_busy`=1: FREEZE mode. State and `cnt` hold. If `br_taken`=1 in the same cycle, set `pend_flush`.
- RUN with flush request: FLUSHING mode. Clear `pend_flush` and increment `flush_cnt`. If FLUSH_CYC>1, go to FLUSH with `cnt`=FLUSH_CYC-1.
- RUN with `luh`: BUBBLE mode. If LU_CYC>1, go to STALL with `cnt`=LU_CYC-1.
- RUN otherwise: NORMAL mode.
- STALL: BUBBLE mode and decrement `cnt`; return to RUN on the cycle `cnt`==1. A flush request in STALL preempts it: FLUSHING mode, then enter FLUSH as from RUN.
- FLUSH: FLUSHING mode and decrement `cnt`; return to RUN when `cnt`==1. A new `br_taken` in FLUSH is ignored, because the wrong-path instruction is already being killed. `flush_cnt` is not incremented for it.
- `stall_cnt` increments in every non-reset cycle with `pc_en`=0 (BUBBLE or FREEZE).
- Both counters saturate at all-ones.

## Timing
- `rst`=0 sampled at a rising edge sets: `state`=RUN, `cnt`=0, `pend_flush`=0, both counters 0.
- While `rst`=0, outputs are forced to `pc_en`=`ifid_en`=`pipe_en`=0, `hazflush`=1, `flush`=0.
- Reset asserted in STALL or FLUSH abandons the sequence. The first cycle after release is RUN.
- Hazard-to-output latency is 0 cycles (combinational). State takes effect on the next edge.
- A load-use hazard costs exactly LU_CYC cycles of `pc_en`=0. A taken branch gives exactly FLUSH_CYC cycles of `flush`=1. `mem_busy` cycles extend both sequences, and counts resume afterward.
- `br_taken` together with `luh` in RUN: flush wins and no bubble is inserted.

## Test plan
- Load `x5` in EX, `add` reading `x5` in ID, LU_CYC=1: one cycle of `pc_en`=0 and `hazflush`=0, then NORMAL; `stall_cnt`=1.
- Same hazard with `ex_rd`=0, or with `id_rs2_used`=0 and the match on rs2 only: NORMAL, no stall.
- `br_taken` pulse with FLUSH_CYC=2: `flush`=1 for 2 cycles with enables 1; `flush_cnt`=1; `state` goes RUN→FLUSH→RUN.
- `br_taken`=1 with `mem_busy`=1 for 3 cycles: FREEZE for 3 cycles with `flush`=0, then `flush`=1 on the first non-busy cycle; `stall_cnt`=3.
- LU_CYC=3, `rst` driven low on the second STALL cycle: outputs go to reset values, `stall_cnt` reads 0 after reset, `state`=RUN.
- CNTW=4 with 20 load-use stalls: `stall_cnt` saturates at 15.
